// File: rtl/fpga_uart_pkg.sv
// ============================================================================
// Module   : fpga_uart_pkg
// Purpose  : Shared types and constants for the FPGA-side UART receive monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fpga_uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

endpackage

`default_nettype wire

// File: rtl/fpga_uart_rx_sync.sv
// ============================================================================
// Module   : fpga_uart_rx_sync
// Purpose  : Multi-flop synchronizer for idle-high async lines (reset to 1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module fpga_uart_rx_sync
  import fpga_uart_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk_gen,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fpga_uart_rx_monitor.sv
// ============================================================================
// Module   : fpga_uart_rx_monitor
// Purpose  : 8N1 UART receiver with valid/ready byte port, framing/overrun
//            flags; define FPGA_UART_RX_PARITY_EN for an even-parity bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fpga_uart_rx_monitor
  import fpga_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 130,
  parameter int CNT_W        = 16
) (
  input  logic       clk_gen,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
`ifdef FPGA_UART_RX_PARITY_EN
  ,
  output logic       parity_err_o
`endif
);

  localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       c_LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 w_rx_s;
  rx_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [2:0]           r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 w_stop_ok, w_stop_bad, w_load_ok;
  logic [7:0]           r_data;
  logic                 r_valid, r_frame_err, r_overrun;

  fpga_uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_gen (clk_gen),
    .rst_n   (rst_n),
    .i_async (rx_i),
    .o_sync  (w_rx_s)
  );

`ifdef FPGA_UART_RX_PARITY_EN
  logic r_par_bit, w_par_nxt, w_par_bad, r_parity_err;

  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign w_par_bad    = ^{r_shift, r_par_bit};
  assign w_load_ok    = w_stop_ok && !w_par_bad;
  assign parity_err_o = r_parity_err;
`else
  assign w_load_ok    = w_stop_ok;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + CNT_W'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_stop_ok     = 1'b0;
    w_stop_bad    = 1'b0;
`ifdef FPGA_UART_RX_PARITY_EN
    w_par_nxt     = r_par_bit;
`endif
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = START;
      end
      START: begin
        if (r_cnt == c_HALF_LAST) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == c_BIT_LAST) begin
          w_cnt_nxt     = '0;
          w_shift_nxt   = {w_rx_s, r_shift[DATA_BITS-1:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
`ifdef FPGA_UART_RX_PARITY_EN
          if (r_bit_idx == c_LAST_BIT) w_state_nxt = PARITY;
`else
          if (r_bit_idx == c_LAST_BIT) w_state_nxt = STOP;
`endif
        end
      end
`ifdef FPGA_UART_RX_PARITY_EN
      PARITY: begin
        if (r_cnt == c_BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = w_rx_s;
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (r_cnt == c_BIT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_stop_ok   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must go high before a new start is accepted.
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_load_ok && r_valid && !ready_i;
      // A same-cycle handshake frees the holding register for the new byte.
      if (w_load_ok && (!r_valid || ready_i)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef FPGA_UART_RX_PARITY_EN
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_par_bit    <= w_par_nxt;
      r_parity_err <= w_stop_ok && w_par_bad;
    end
  end
`endif

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;
  assign busy_o      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fpga_uart_rx_monitor.sv
// ============================================================================
// Module   : tb_fpga_uart_rx_monitor
// Purpose  : Self-checking bench for fpga_uart_rx_monitor at 16 clocks/bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fpga_uart_rx_monitor;

  localparam int CPB = 16;

  logic       clk_gen = 1'b0;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;
`ifdef FPGA_UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Observed behaviour collected by the monitor
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int valid_cycles, ferr_cnt, ovr_cnt, perr_cnt;

  fpga_uart_rx_monitor #(
    .CLKS_PER_BIT (CPB),
    .CNT_W        (16)
  ) dut (
    .clk_gen     (clk_gen),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
`ifdef FPGA_UART_RX_PARITY_EN
    ,
    .parity_err_o (parity_err_o)
`endif
  );

  always #5 clk_gen = ~clk_gen;

  always @(negedge clk_gen) begin
    if (rst_n) begin
      if (valid_o && ready_i) rx_q.push_back(data_o);
      if (valid_o)     valid_cycles++;
      if (frame_err_o) ferr_cnt++;
      if (overrun_o)   ovr_cnt++;
`ifdef FPGA_UART_RX_PARITY_EN
      if (parity_err_o) perr_cnt++;
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_gen);
      #1;
    end
  endtask

  task automatic clear_obs();
    rx_q.delete();
    exp_q.delete();
    valid_cycles = 0;
    ferr_cnt     = 0;
    ovr_cnt      = 0;
    perr_cnt     = 0;
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    tick(CPB);
  endtask

  // Line-level UART transmitter: start, 8 data LSB first, [parity], stop
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef FPGA_UART_RX_PARITY_EN
    drive_bit(par_v);
`else
    if (par_v) rx_i = 1'b1;
`endif
    drive_bit(stop_v);
    rx_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_i = 1'b1; ready_i = 1'b0;
    tick(3);
    n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    n_checks++; if (data_o !== 8'h00) begin n_errors++; $display("FAIL rst_data: got %h want 00", data_o); end
    rst_n = 1'b1;
    tick(3);
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    n_checks++; if (frame_err_o !== 1'b0) begin n_errors++; $display("FAIL rst_ferr: got %b want 0", frame_err_o); end
    n_checks++; if (overrun_o !== 1'b0) begin n_errors++; $display("FAIL rst_ovr: got %b want 0", overrun_o); end
  endtask

  task automatic test_single();
    clear_obs();
    ready_i = 1'b1;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    tick(20);
    n_checks++; if (rx_q.size() != 1) begin n_errors++; $display("FAIL single_count: got %0d want 1", rx_q.size()); end
    else begin
      n_checks++; if (rx_q[0] !== 8'hA5) begin n_errors++; $display("FAIL single_data: got %h want a5", rx_q[0]); end
    end
    n_checks++; if (valid_cycles != 1) begin n_errors++; $display("FAIL single_valid_len: got %0d want 1", valid_cycles); end
    n_checks++; if (ferr_cnt != 0) begin n_errors++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt); end
    n_checks++; if (ovr_cnt != 0) begin n_errors++; $display("FAIL single_ovr: got %0d want 0", ovr_cnt); end
  endtask

  task automatic test_overrun();
    clear_obs();
    ready_i = 1'b0;
    send_frame(8'h3C, 1'b1, ^8'h3C);
    send_frame(8'h81, 1'b1, ^8'h81);
    tick(20);
    n_checks++; if (valid_o !== 1'b1) begin n_errors++; $display("FAIL ovr_valid_held: got %b want 1", valid_o); end
    n_checks++; if (data_o !== 8'h3C) begin n_errors++; $display("FAIL ovr_data_held: got %h want 3c", data_o); end
    n_checks++; if (ovr_cnt != 1) begin n_errors++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt); end
    ready_i = 1'b1;
    tick(1);
    n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL ovr_valid_drop: got %b want 0", valid_o); end
    n_checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin n_errors++;
      $display("FAIL ovr_handshake: got %0d bytes first %h want 1 byte 3c", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00); end
  endtask

  task automatic test_framing();
    clear_obs();
    ready_i = 1'b1;
    send_frame(8'h55, 1'b0, ^8'h55);
    rx_i = 1'b0;
    tick(100);
    n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL frm_busy_break: got %b want 1", busy_o); end
    rx_i = 1'b1;
    tick(10);
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL frm_busy_after: got %b want 0", busy_o); end
    n_checks++; if (ferr_cnt != 1) begin n_errors++; $display("FAIL frm_pulses: got %0d want 1", ferr_cnt); end
    n_checks++; if (valid_cycles != 0) begin n_errors++; $display("FAIL frm_valid: got %0d cycles want 0", valid_cycles); end
    send_frame(8'h12, 1'b1, ^8'h12);
    tick(20);
    n_checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h12) begin n_errors++;
      $display("FAIL frm_next_byte: got %0d bytes first %h want 1 byte 12", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00); end
    n_checks++; if (ferr_cnt != 1) begin n_errors++; $display("FAIL frm_next_ferr: got %0d want 1", ferr_cnt); end
  endtask

  task automatic test_glitch();
    logic saw_busy;
    clear_obs();
    saw_busy = 1'b0;
    rx_i = 1'b0;
    tick(5);
    rx_i = 1'b1;
    saw_busy = busy_o;
    tick(30);
    n_checks++; if (saw_busy !== 1'b1) begin n_errors++; $display("FAIL glitch_started: got %b want 1", saw_busy); end
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL glitch_idle: got %b want 0", busy_o); end
    n_checks++; if (valid_cycles != 0 || ferr_cnt != 0 || ovr_cnt != 0) begin n_errors++;
      $display("FAIL glitch_quiet: got valid %0d ferr %0d ovr %0d want 0 0 0", valid_cycles, ferr_cnt, ovr_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    clear_obs();
    b = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    rx_i = b[3];
    tick(CPB / 2);
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 8'h00) begin n_errors++;
      $display("FAIL midrst_outputs: got busy %b valid %b data %h want 0 0 00", busy_o, valid_o, data_o); end
    rx_i = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    send_frame(8'hF0, 1'b1, ^8'hF0);
    tick(20);
    n_checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hF0) begin n_errors++;
      $display("FAIL midrst_byte: got %0d bytes first %h want 1 byte f0", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00); end
    n_checks++; if (ferr_cnt != 0) begin n_errors++; $display("FAIL midrst_ferr: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_random_stream();
    logic [7:0] b;
    clear_obs();
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1, ^b);
      tick($urandom_range(0, 20));
    end
    tick(20);
    n_checks++; if (rx_q.size() != exp_q.size()) begin n_errors++;
      $display("FAIL rand_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_errors++;
        $display("FAIL rand_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (ferr_cnt != 0 || ovr_cnt != 0) begin n_errors++;
      $display("FAIL rand_errors: got ferr %0d ovr %0d want 0 0", ferr_cnt, ovr_cnt); end
  endtask

`ifdef FPGA_UART_RX_PARITY_EN
  task automatic test_parity();
    clear_obs();
    ready_i = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    tick(20);
    n_checks++; if (perr_cnt != 1) begin n_errors++; $display("FAIL par_bad_pulse: got %0d want 1", perr_cnt); end
    n_checks++; if (valid_cycles != 0) begin n_errors++; $display("FAIL par_bad_valid: got %0d want 0", valid_cycles); end
    send_frame(8'h07, 1'b1, 1'b1);
    tick(20);
    n_checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h07) begin n_errors++;
      $display("FAIL par_good_byte: got %0d bytes first %h want 1 byte 07", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00); end
    n_checks++; if (perr_cnt != 1) begin n_errors++; $display("FAIL par_good_pulse: got %0d want 1", perr_cnt); end
  endtask
`endif

  initial begin
    clear_obs();
    test_reset();
    test_single();
    test_overrun();
    test_framing();
    test_glitch();
    test_reset_mid_frame();
    test_random_stream();
`ifdef FPGA_UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpga_uart_rx_monitor.md
Name: fpga_uart_rx_monitor

Overview:
FPGA-side UART receiver on the board wrapper. It listens on the SoC's UART transmit pin, which is the opposite end of the SoC UART. It decodes 8N1 frames into bytes for on-FPGA consumers (LED/debug logic, exit-message sniffer) through a valid/ready byte port. It flags framing, overrun and, optionally, parity errors. No CPU involvement; it sits beside the SoC instance in the wrapper.

Parameters:
CLKS_PER_BIT, 130, clk_gen cycles per UART bit (15 MHz / 115200); legal range 8..65535.
CNT_W, 16, width of the bit-timing counter; must hold CLKS_PER_BIT-1.

Ports:
clk_gen  input  1  system clock from the clock wizard
rst_n  input  1  reset; asynchronous, active-low
rx_i  input  1  SoC uart_tx line; asynchronous, idle high
data_o  output  8  received byte, LSB = first data bit
valid_o  output  1  data_o holds an unconsumed byte
ready_i  input  1  consumer accepts the byte when valid_o && ready_i
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  one-cycle pulse: byte completed while holding register full
busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset: everything clears asynchronously on rst_n low. data_o=0, valid_o=0, all pulses=0, busy_o=0, FSM=IDLE, synchronizer flops=1.
- rx_i passes through a 2-flop synchronizer (reset value 1). All decisions use the synced value rx_s. This adds 2 cycles of input latency.
- States: IDLE, START, DATA, STOP, WAIT_HIGH. Bit counter bit_idx is 3 bits; timing counter cnt is CNT_W bits.
- IDLE: on rx_s==0, go to START and set cnt=0.
- START: when cnt==CLKS_PER_BIT/2-1 (integer division), sample rx_s.
  - rx_s==0: go to DATA with cnt=0, bit_idx=0.
  - rx_s==1: glitch; return to IDLE with no error.
- DATA: when cnt==CLKS_PER_BIT-1, shift rx_s into bit 7 of the shift register (right shift), reset cnt, increment bit_idx. After bit_idx==7 is sampled, go to STOP. Sample points are therefore at mid-bit.
- STOP: when cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: deliver the byte and go to IDLE.
  - rx_s==0: pulse frame_err_o for 1 cycle, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break condition from re-triggering.
- Delivery (the cycle after the stop sample):
  - Holding register empty, or valid_o && ready_i in the same cycle: load data_o and set valid_o=1.
  - Otherwise: pulse overrun_o, drop the new byte, keep the old data_o and valid_o.
- valid_o clears the cycle after valid_o && ready_i, unless a new byte is loaded in that same cycle. data_o is stable while valid_o=1.
- ready_i is ignored while valid_o=0.
- Latency: valid_o rises 1 cycle after the stop-bit sample, i.e. about 9.5 bit times plus 3 cycles after the falling start edge on rx_i.
- cnt never wraps; it resets on every sample or state change.

Optional Feature:
Macro: FPGA_UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one bit at mid-bit.
  - Even parity is checked over the 8 data bits plus the parity bit.
  - A mismatch pulses parity_err_o (extra 1-bit output port, reset 0) in the delivery cycle and drops the byte; valid_o does not rise.
  - A frame with both a parity error and a framing error pulses only frame_err_o.
- Undefined: no PARITY state, no parity_err_o port, 8N1 only.

Decomposition:
- Package fpga_uart_pkg:
  - rx_state_e enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; PARITY is always declared).
  - localparam DATA_BITS=8.
  - localparam SYNC_STAGES=2.
- Sub-module fpga_uart_rx_sync: a 2-flop synchronizer with reset value 1. It is reusable for jtag/gpio monitors.

Test Plan:
All cases use CLKS_PER_BIT=16.
1. Send 0xA5 (8N1, 16 cycles/bit), ready_i=1 -> valid_o pulses 1 cycle with data_o=0xA5; frame_err_o, overrun_o stay 0.
2. Send 0x3C then 0x81 back-to-back with ready_i=0 -> valid_o=1 with data_o=0x3C held; overrun_o pulses once at the end of the second frame; raise ready_i -> valid_o drops next cycle, data_o still 0x3C at the handshake.
3. Send 0x55 with the stop bit forced low, then hold rx_i low 100 cycles -> frame_err_o pulses once, valid_o stays 0, busy_o=1 until rx_i returns high, then the next frame 0x12 is received correctly.
4. Drive a 5-cycle low glitch on rx_i -> FSM returns to IDLE, no valid_o, no error pulses.
5. Assert rst_n low mid-frame (during data bit 3), release, send 0xF0 -> outputs are 0 during reset, the partial frame is discarded, 0xF0 is received cleanly.
6. (FPGA_UART_RX_PARITY_EN) Send 0x07 with parity bit 0 -> parity_err_o pulses, valid_o stays 0; send 0x07 with parity bit 1 -> data_o=0x07, valid_o=1.
